data_load_unit: RTL and testbench

Load-side counterpart of the data memory's store path. Accepts a load request (byte address plus RISC-V load `func_3`), reads one or two 32-bit words from the data memory's combinational word read port, then extracts, aligns and sign/zero-extends the addressed byte, halfword or word. Sits between the core's load/store stage and `Big_Memory`'s extract port. Returns the result on a valid/ready response channel.

---
 rtl/data_load_unit_pkg.sv | 54 +++++
 rtl/data_load_unit_if.sv | 37 +++
 rtl/data_load_unit_load_extend.sv | 30 +++
 rtl/data_load_unit.sv | 137 +++++++++++++
 tb/tb_data_load_unit.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_load_unit_pkg.sv
// Shared types and helpers for the data load unit: RISC-V load func3
// codes, FSM state encoding and access-size decoding.
package data_load_unit_pkg;

  // Load func3 codes; they sit alongside the store codes SB=000, SH=001, SW=010.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // FSM state encodings.
  localparam logic [1:0] ENC_IDLE = 2'd0;
  localparam logic [1:0] ENC_RD0  = 2'd1;
  localparam logic [1:0] ENC_RD1  = 2'd2;
  localparam logic [1:0] ENC_RESP = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ENC_IDLE,
    ST_RD0  = ENC_RD0,
    ST_RD1  = ENC_RD1,
    ST_RESP = ENC_RESP
  } state_t;

  // True for the five load codes the unit understands.
  function automatic logic func3_legal(input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Number of bytes moved by a load; 0 for illegal codes.
  function automatic logic [2:0] access_bytes(input logic [2:0] f3);
    logic [2:0] n;
    case (f3)
      F3_LB, F3_LBU: n = 3'd1;
      F3_LH, F3_LHU: n = 3'd2;
      F3_LW:         n = 3'd4;
      default:       n = 3'd0;
    endcase
    return n;
  endfunction

  // An access needs a second word when its last byte falls past byte 3.
  // offset (max 3) plus size (max 4) fits in three bits.
  function automatic logic spans_two_words(input logic [1:0] offset,
                                           input logic [2:0] f3);
    return ({1'b0, offset} + access_bytes(f3)) > 3'd4;
  endfunction

endpackage

// File: rtl/data_load_unit_if.sv
// Bus bundle between the load/store stage, the data load unit and the
// data memory's combinational word read port.
//
// Handshake rules for both req_* and rsp_* channels: a transfer happens
// on a rising edge where valid and ready are both high. Once the source
// raises valid it keeps valid and its payload stable until that edge.
// ready may rise and fall freely and never depends on a future valid.
// mem_rd_addr/mem_rd_data is not a handshake: data returns in the same cycle.
interface data_load_unit_if #(
  parameter int ADDR_W = 7,
  parameter int IDX_W  = 5
) ();
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_func3;

  logic [IDX_W-1:0]  mem_rd_addr;
  logic [31:0]       mem_rd_data;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_err;

  // The load unit itself.
  modport slave (
    input  req_valid, req_addr, req_func3, mem_rd_data, rsp_ready,
    output req_ready, mem_rd_addr, rsp_valid, rsp_data, rsp_err
  );

  // The environment: request source, memory and response consumer.
  modport master (
    output req_valid, req_addr, req_func3, mem_rd_data, rsp_ready,
    input  req_ready, mem_rd_addr, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/data_load_unit_load_extend.sv
// Combinational load extraction: selects the addressed byte, halfword or
// word out of a two-word window and sign/zero-extends it to 32 bits.
// Kept separate so any other load path can reuse it.
module load_extend
  import data_load_unit_pkg::*;
(
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  func3_i,
  output logic [31:0] data_o
);

  logic [31:0] window;

  // Shift the addressed byte down to bit 0, then extend by load type.
  always_comb begin
    window = 32'({hi_i, lo_i} >> {offset_i, 3'b000});
    data_o = '0;
    case (func3_i)
      F3_LB:   data_o = {{24{window[7]}},  window[7:0]};
      F3_LH:   data_o = {{16{window[15]}}, window[15:0]};
      F3_LW:   data_o = window;
      F3_LBU:  data_o = {24'd0, window[7:0]};
      F3_LHU:  data_o = {16'd0, window[15:0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/data_load_unit.sv
// Data load unit: accepts one load request at a time, reads one or two
// words from the data memory, extracts/extends the addressed data and
// returns it on a valid/ready response channel.
module data_load_unit
  import data_load_unit_pkg::*;
#(
  parameter int WORDS  = 32,
  parameter int ADDR_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  data_load_unit_if.slave  bus,
  output state_t           dbg_state_o
);

  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t            state_q;
  logic [1:0]        offset_q;
  logic [2:0]        func3_q;
  logic [31:0]       lo_q;
  logic [IDX_W-1:0]  mem_rd_addr_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_data_q;
  logic              rsp_err_q;

  logic [IDX_W-1:0]  next_idx_d;
  logic [31:0]       ext_hi;
  logic [31:0]       ext_lo;
  logic [31:0]       ext_data;
  logic              span;

  // Second word of a spanning access; the last word wraps to word 0.
  always_comb begin
    if (mem_rd_addr_q == LAST_IDX) next_idx_d = '0;
    else                           next_idx_d = mem_rd_addr_q + IDX_W'(1);
  end

  // Extraction window: in RD0 the live word is the low half (high half is
  // zero for a non-spanning access); in RD1 the live word is the high half.
  always_comb begin
    if (state_q == ST_RD1) begin
      ext_lo = lo_q;
      ext_hi = bus.mem_rd_data;
    end else begin
      ext_lo = bus.mem_rd_data;
      ext_hi = '0;
    end
  end

  assign span = spans_two_words(offset_q, func3_q);

  load_extend u_extend (
    .hi_i     (ext_hi),
    .lo_i     (ext_lo),
    .offset_i (offset_q),
    .func3_i  (func3_q),
    .data_o   (ext_data)
  );

  // Request/read/respond sequencer; all outputs except req_ready are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      offset_q      <= '0;
      func3_q       <= '0;
      lo_q          <= '0;
      mem_rd_addr_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            offset_q <= bus.req_addr[1:0];
            func3_q  <= bus.req_func3;
            if (!func3_legal(bus.req_func3)) begin
              // Illegal code: answer immediately, never touch memory.
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q       <= ST_RD0;
              mem_rd_addr_q <= bus.req_addr[ADDR_W-1:2];
            end
          end
        end

        ST_RD0: begin
          lo_q <= bus.mem_rd_data;
          if (span) begin
            state_q       <= ST_RD1;
            mem_rd_addr_q <= next_idx_d;
          end else begin
            state_q       <= ST_RESP;
            mem_rd_addr_q <= '0;
            rsp_valid_q   <= 1'b1;
            rsp_data_q    <= ext_data;
            rsp_err_q     <= 1'b0;
          end
        end

        ST_RD1: begin
          state_q       <= ST_RESP;
          mem_rd_addr_q <= '0;
          rsp_valid_q   <= 1'b1;
          rsp_data_q    <= ext_data;
          rsp_err_q     <= 1'b0;
        end

        ST_RESP: begin
          // Result is held until the consumer takes it.
          if (bus.rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Only IDLE accepts; reset masks acceptance while it is asserted.
  assign bus.req_ready   = (state_q == ST_IDLE) && !reset;
  assign bus.mem_rd_addr = mem_rd_addr_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_data_load_unit.sv
// Bench for data_load_unit: directed vector table from the memory preload,
// hand-written backpressure and reset-abort sequences, then random loads
// checked against a byte-level reference model.
module tb_data_load_unit;
  import data_load_unit_pkg::*;

  localparam int WORDS  = 32;
  localparam int ADDR_W = 7;
  localparam int IDX_W  = 5;
  localparam int NBYTES = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   reset;
  state_t dbg_state;

  always #5 clk = ~clk;

  data_load_unit_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) bus ();

  data_load_unit #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Combinational word read port of the data memory.
  logic [31:0] mem [WORDS];
  assign bus.mem_rd_data = mem[bus.mem_rd_addr];

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [IDX_W-1:0] exp_q[$];   // expected mem_rd_addr sequence of current load

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: assemble the load byte by byte from memory.
  function automatic logic [31:0] model_load(input logic [ADDR_W-1:0] addr, input logic [2:0] f3,
                                             output logic err, output int nwords);
    int size;
    int a;
    logic [31:0] v;
    err = 1'b0;
    nwords = 1;
    case (f3)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      3'b010:         size = 4;
      default: begin
        err = 1'b1;
        nwords = 0;
        return 32'h0;
      end
    endcase
    v = 32'h0;
    for (int i = 0; i < size; i++) begin
      a = (int'(addr) + i) % NBYTES;
      v = v | (32'(mem[a / 4][8 * (a % 4) +: 8]) << (8 * i));
    end
    if ((int'(addr) % 4) + size > 4) nwords = 2;
    if (f3 == 3'b000 && v[7])  v = v | 32'hFFFFFF00;
    if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic [ADDR_W-1:0] addr, input logic [2:0] f3);
    int guard = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_func3 = f3;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) check("req_ready_timeout", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Waits for rsp_valid, checking every read cycle against exp_q.
  // lat counts edges from acceptance to the edge that first samples rsp_valid.
  task automatic collect_rsp(output logic [31:0] data, output logic err, output int lat);
    lat = 1;
    @(negedge clk);
    while (!bus.rsp_valid && lat < 12) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got index %0d required none", bus.mem_rd_addr);
      end else begin
        check("rd_addr", 32'(bus.mem_rd_addr), 32'(exp_q.pop_front()));
      end
      @(negedge clk);
      lat++;
    end
    if (!bus.rsp_valid) check("rsp_valid_timeout", 32'(bus.rsp_valid), 32'd1);
    check("reads_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    check("rd_addr_in_resp", 32'(bus.mem_rd_addr), 32'd0);
    data = bus.rsp_data;
    err  = bus.rsp_err;
  endtask

  task automatic take_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check("rsp_valid_after_hs", 32'(bus.rsp_valid), 32'd0);
    check("req_ready_after_hs", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic do_txn(input string name, input logic [ADDR_W-1:0] addr, input logic [2:0] f3,
                        input logic [31:0] exp_data, input logic exp_err, input int exp_lat,
                        input int hold);
    logic [31:0] d;
    logic        e;
    int          lat;
    exp_q.delete();
    if (!exp_err)
      for (int i = 0; i < exp_lat - 1; i++)
        exp_q.push_back(IDX_W'(((int'(addr) >> 2) + i) % WORDS));
    send_req(addr, f3);
    collect_rsp(d, e, lat);
    check({name, "_data"}, d, exp_data);
    check({name, "_err"}, 32'(e), 32'(exp_err));
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({name, "_hold_data"}, bus.rsp_data, exp_data);
      check({name, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
      check({name, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
    end
    take_rsp();
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        f3;
    logic [31:0]       data;
    logic              err;
    logic [3:0]        lat;
  } vec_t;

  vec_t vecs [0:15];

  task automatic check_reset_outputs(input string name);
    check({name, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({name, "_rsp_data"}, bus.rsp_data, 32'd0);
    check({name, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
    check({name, "_rd_addr"}, 32'(bus.mem_rd_addr), 32'd0);
    check({name, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] d;
    logic        e;
    int          lat;
    int          nw;
    logic [2:0]  legal [5];
    logic [ADDR_W-1:0] ra;
    logic [2:0]  rf;
    logic [31:0] rexp;
    logic        rerr;

    legal = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    vecs = '{
      '{7'h0B, 3'b000, 32'hFFFFFFDD, 1'b0, 4'd2},
      '{7'h0B, 3'b100, 32'h000000DD, 1'b0, 4'd2},
      '{7'h08, 3'b101, 32'h0000BBAA, 1'b0, 4'd2},
      '{7'h08, 3'b001, 32'hFFFFBBAA, 1'b0, 4'd2},
      '{7'h09, 3'b001, 32'hFFFFCCBB, 1'b0, 4'd2},
      '{7'h0A, 3'b010, 32'h2211DDCC, 1'b0, 4'd3},
      '{7'h7F, 3'b001, 32'h00001280, 1'b0, 4'd3},
      '{7'h0B, 3'b101, 32'h000011DD, 1'b0, 4'd3},
      '{7'h0C, 3'b010, 32'h44332211, 1'b0, 4'd2},
      '{7'h7F, 3'b000, 32'hFFFFFF80, 1'b0, 4'd2},
      '{7'h7C, 3'b010, 32'h80000000, 1'b0, 4'd2},
      '{7'h0E, 3'b001, 32'h00004433, 1'b0, 4'd2},
      '{7'h0F, 3'b010, 32'h00000044, 1'b0, 4'd3},
      '{7'h03, 3'b100, 32'h00000000, 1'b0, 4'd2},
      '{7'h0B, 3'b011, 32'h00000000, 1'b1, 4'd1},
      '{7'h7C, 3'b111, 32'h00000000, 1'b1, 4'd1}
    };

    for (int w = 0; w < WORDS; w++) mem[w] = 32'h0;
    mem[0]  = 32'h00000012;
    mem[2]  = 32'hDDCCBBAA;
    mem[3]  = 32'h44332211;
    mem[31] = 32'h80000000;

    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_func3 = '0;
    bus.rsp_ready = 1'b0;

    // Reset values while reset is held, then right after release.
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
    check_reset_outputs("post_rst");

    // Directed vectors.
    for (int i = 0; i < 16; i++)
      do_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].f3, vecs[i].data,
             vecs[i].err, int'(vecs[i].lat), 0);

    // Backpressure: response held 3 cycles while stray requests are offered.
    exp_q.delete();
    exp_q.push_back(IDX_W'(3));
    send_req(7'h0C, 3'b010);
    collect_rsp(d, e, lat);
    check("bp_data", d, 32'h44332211);
    check("bp_lat", 32'(lat), 32'd2);
    for (int h = 0; h < 3; h++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 7'h08;
      bus.req_func3 = 3'b001;
      @(negedge clk);
      check("bp_hold_data", bus.rsp_data, 32'h44332211);
      check("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    take_rsp();
    @(negedge clk);
    check("bp_no_stray_valid", 32'(bus.rsp_valid), 32'd0);
    check("bp_no_stray_state", 32'(dbg_state), 32'(ST_IDLE));

    // Reset during RD1 of a spanning LW aborts it.
    send_req(7'h0A, 3'b010);
    @(negedge clk);
    check("abort_rd0_addr", 32'(bus.mem_rd_addr), 32'd2);
    @(negedge clk);
    check("abort_rd1_addr", 32'(bus.mem_rd_addr), 32'd3);
    check("abort_rd1_valid", 32'(bus.rsp_valid), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_req_ready", 32'(bus.req_ready), 32'd0);
    check_reset_outputs("abort");
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    do_txn("after_abort", 7'h08, 3'b010, 32'hDDCCBBAA, 1'b0, 2, 0);

    // Random loads against the reference model.
    for (int t = 0; t < 60; t++) begin
      for (int w = 0; w < WORDS; w++) mem[w] = $urandom;
      ra = ADDR_W'($urandom_range(0, NBYTES - 1));
      if ($urandom_range(0, 9) < 8) rf = legal[$urandom_range(0, 4)];
      else                          rf = 3'($urandom_range(0, 7));
      rexp = model_load(ra, rf, rerr, nw);
      do_txn($sformatf("rnd%0d", t), ra, rf, rexp, rerr,
             rerr ? 1 : (nw == 2 ? 3 : 2), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
